mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the cache request interface. It accepts instruction-fetch requests from the icache (iREN/iaddr, answered with iwait/iload) and data requests from the dcache (dREN/dWEN/daddr/dstore, answered with dwait/dload). It arbitrates between the two, runs one RAM transaction at a time through a registered state machine, and returns results with a single-cycle wait-low handshake. It sits between the caches and the RAM model and replaces purely combinational routing.

## Interface
Parameters:
- ISTARVE_MAX, 4: consecutive dcache grants allowed while iREN is pending; the next grant is then forced to the icache. Range 1..15.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  0 only in the cycle iload is valid for the icache
- iload  out  32  instruction word returned
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request; wins if asserted together with dREN
- daddr  in  32  dcache address
- dstore  in  32  dcache write data
- dwait  out  1  0 only in the cycle a dcache op completes
- dload  out  32  data word returned for reads
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ramstate = ACCESS
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

## Operation
- States: IDLE, ACCESS, RETRY, RESP.
- IDLE: arbitrate among live requests. Priority: dcache first unless the starvation counter equals ISTARVE_MAX and iREN=1. On a grant:
  - latch requester (I/D), op (read/write), address and store data;
  - go to ACCESS.
  - With no request, stay in IDLE.
- Starvation counter (4-bit):
  - +1 on each dcache grant while iREN=1;
  - cleared on an icache grant, or when iREN=0 at arbitration;
  - saturates at ISTARVE_MAX.
- ACCESS: drive ramREN or ramWEN from the latched op, and ramaddr/ramstore from the latched registers.
  - ramstate = ACCESS: capture ramload into a return register (reads) and go to RESP.
  - ramstate = ERROR: go to RETRY.
  - FREE/BUSY: hold.
- RETRY: all RAM strobes 0 for one cycle, then back to ACCESS with the same latched request.
- RESP: the granted side's wait = 0 and its load = the captured word; the other side's wait stays 1. Next state is IDLE.
- Abort, for reads only. In ACCESS or RETRY, if the granted requester's REN drops, or its live address differs from the latched address:
  - drop the strobes and go to IDLE next cycle;
  - no RESP and no wait-low.
  - Writes are never aborted.
- iload/dload hold their last returned value outside RESP.
- The latched request is never altered mid-transaction.

## Timing
- Reset values: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0; state IDLE; counter 0; latched registers 0.
- All outputs come from registers or state decode only. No combinational path from any request input to any RAM output.
- Request seen in IDLE at cycle 0 → ram strobe at cycle 1.
  - If ramstate = ACCESS in cycle 1, wait = 0 in cycle 2 (minimum latency 2).
  - Each FREE/BUSY cycle adds 1; each ERROR adds 2.
- Wait low lasts exactly one cycle; the earliest next grant is the cycle after RESP.
- Requests arriving during ACCESS/RETRY/RESP are held by the requester (wait=1) and arbitrated in the next IDLE.
- Reset mid-transaction immediately returns all outputs to their reset values; there is no RAM write completion after reset.

## Test plan
- Single ifetch: iREN=1, iaddr=0x40, RAM answers ACCESS on first strobe with 0x8C220004 → ramREN=1 at cycle 1, iwait=0 and iload=0x8C220004 at cycle 2 only, dwait stays 1.
- Contention: iREN and dWEN (daddr=0x100, dstore=0xDEADBEEF) raised together → write serviced first (ramWEN, ramstore=0xDEADBEEF), dwait low once, then icache read, iwait low once.
- Starvation, ISTARVE_MAX=4: dREN held continuously with iREN=1 → exactly 4 dcache grants, then an icache grant, then the dcache again.
- RAM ERROR then ACCESS: ramstate ERROR during first ACCESS → one cycle with strobes 0, reissue of the same address, completion 2 cycles later than nominal.
- Abort: iaddr changes 0x40→0x44 while ramstate=BUSY → strobes drop, no iwait-low for 0x40, new request for 0x44 completes normally.
- Reset mid-write: nRST low during ACCESS with ramWEN=1 → ramWEN, dwait=1 and all outputs at reset values asynchronously; after release, IDLE with counter 0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates icache/dcache requests onto a single RAM port,
// one transaction at a time, with registered strobes and single-cycle wait-low replies.
module mem_responder #(
  parameter int unsigned ISTARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {StIdle, StAccess, StRetry, StResp} state_e;

  localparam logic [1:0] RamAccess = 2'd2;
  localparam logic [1:0] RamError  = 2'd3;
  localparam logic [3:0] StarveMax = 4'(ISTARVE_MAX);

  state_e      state_q;
  logic [3:0]  starve_q;
  logic        req_d_q;
  logic        req_wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ren_q;
  logic        wen_q;
  logic        iwait_q;
  logic        dwait_q;
  logic [31:0] iload_q;
  logic [31:0] dload_q;

  logic        force_i;
  logic        grant_d;
  logic        grant_i;
  logic        live_ren;
  logic [31:0] live_addr;
  logic        abort;

  always_comb begin
    force_i   = iREN && (starve_q == StarveMax);
    grant_d   = (dREN || dWEN) && !force_i;
    grant_i   = iREN && !grant_d;
    live_ren  = req_d_q ? dREN : iREN;
    live_addr = req_d_q ? daddr : iaddr;
    // A read whose requester moved on is stale; writes always run to completion.
    abort     = !req_wr_q && (!live_ren || (live_addr != addr_q));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= StIdle;
      starve_q <= 4'd0;
      req_d_q  <= 1'b0;
      req_wr_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      iwait_q  <= 1'b1;
      dwait_q  <= 1'b1;
      iload_q  <= 32'd0;
      dload_q  <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_d) begin
            req_d_q  <= 1'b1;
            req_wr_q <= dWEN;
            addr_q   <= daddr;
            wdata_q  <= dstore;
            ren_q    <= !dWEN;
            wen_q    <= dWEN;
            state_q  <= StAccess;
            if (!iREN) starve_q <= 4'd0;
            else if (starve_q != StarveMax) starve_q <= starve_q + 4'd1;
          end else if (grant_i) begin
            req_d_q  <= 1'b0;
            req_wr_q <= 1'b0;
            addr_q   <= iaddr;
            ren_q    <= 1'b1;
            wen_q    <= 1'b0;
            state_q  <= StAccess;
            starve_q <= 4'd0;
          end else begin
            starve_q <= 4'd0;
          end
        end
        StAccess: begin
          if (abort) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            state_q <= StIdle;
          end else if (ramstate == RamAccess) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            state_q <= StResp;
            if (req_d_q) begin
              dwait_q <= 1'b0;
              if (!req_wr_q) dload_q <= ramload;
            end else begin
              iwait_q <= 1'b0;
              iload_q <= ramload;
            end
          end else if (ramstate == RamError) begin
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            state_q <= StRetry;
          end
        end
        StRetry: begin
          if (abort) begin
            state_q <= StIdle;
          end else begin
            ren_q   <= !req_wr_q;
            wen_q   <= req_wr_q;
            state_q <= StAccess;
          end
        end
        StResp: begin
          iwait_q <= 1'b1;
          dwait_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign iwait    = iwait_q;
  assign dwait    = dwait_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed per-cycle vector bench for mem_responder, plus a hand-driven reset-mid-write sequence.
module tb_mem_responder;

  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  mem_responder #(.ISTARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iwait;
    logic        e_dwait;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic iren, input logic [31:0] ia, input logic dren,
                              input logic dwen, input logic [31:0] da, input logic [31:0] ds,
                              input logic [1:0] rs, input logic [31:0] rl, input logic ewi,
                              input logic ewd, input logic [31:0] eil, input logic [31:0] edl,
                              input logic eren, input logic ewen, input logic [31:0] ea,
                              input logic [31:0] es);
    vec_t v;
    v.iren = iren;  v.iaddr = ia;  v.dren = dren;  v.dwen = dwen;
    v.daddr = da;   v.dstore = ds; v.rs = rs;      v.rl = rl;
    v.e_iwait = ewi; v.e_dwait = ewd; v.e_iload = eil; v.e_dload = edl;
    v.e_ren = eren; v.e_wen = ewen; v.e_addr = ea; v.e_store = es;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    logic [31:0] il;
    logic [31:0] dl;
    il = 32'h0;
    dl = 32'h0;

    // Single ifetch, minimum latency
    vt.push_back(mk(1, 32'h40, 0, 0, 0, 0, FREE, 0,            1, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h40, 0, 0, 0, 0, ACC, 32'h8C220004,  1, 1, il, dl, 1, 0, 32'h40, 0));
    il = 32'h8C220004;
    vt.push_back(mk(0, 0, 0, 0, 0, 0, FREE, 0,                 0, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, FREE, 0,                 1, 1, il, dl, 0, 0, 0, 0));

    // Contention: dcache write wins, then icache read
    vt.push_back(mk(1, 32'h80, 0, 1, 32'h100, 32'hDEADBEEF, FREE, 0, 1, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h80, 0, 1, 32'h100, 32'hDEADBEEF, ACC, 0,
                    1, 1, il, dl, 0, 1, 32'h100, 32'hDEADBEEF));
    vt.push_back(mk(1, 32'h80, 0, 1, 32'h100, 32'hDEADBEEF, FREE, 0, 1, 0, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h80, 0, 0, 0, 0, FREE, 0,            1, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h80, 0, 0, 0, 0, ACC, 32'h11111111,  1, 1, il, dl, 1, 0, 32'h80, 0));
    il = 32'h11111111;
    vt.push_back(mk(1, 32'h80, 0, 0, 0, 0, FREE, 0,            0, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, FREE, 0,                 1, 1, il, dl, 0, 0, 0, 0));

    // Starvation: four dcache grants, one icache grant, then dcache again
    for (int k = 0; k < 6; k++) begin
      logic        is_i;
      logic [31:0] word;
      is_i = (k == 4);
      word = is_i ? 32'hA0A0A0A0 : (32'hD0000000 + 32'(k));
      vt.push_back(mk(1, 32'hC0, 1, 0, 32'h200, 0, ACC, 0, 1, 1, il, dl, 0, 0, 0, 0));
      vt.push_back(mk(1, 32'hC0, 1, 0, 32'h200, 0, ACC, word, 1, 1, il, dl, 1, 0,
                      is_i ? 32'hC0 : 32'h200, 0));
      if (is_i) il = word;
      else      dl = word;
      vt.push_back(mk(1, 32'hC0, 1, 0, 32'h200, 0, ACC, 0, !is_i, is_i, il, dl, 0, 0, 0, 0));
    end
    vt.push_back(mk(0, 0, 0, 0, 0, 0, FREE, 0,                 1, 1, il, dl, 0, 0, 0, 0));

    // RAM error then access: one dead cycle, same address reissued
    vt.push_back(mk(1, 32'h300, 0, 0, 0, 0, FREE, 0,           1, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h300, 0, 0, 0, 0, ERR, 0,            1, 1, il, dl, 1, 0, 32'h300, 0));
    vt.push_back(mk(1, 32'h300, 0, 0, 0, 0, ACC, 32'hFFFFFFFF, 1, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h300, 0, 0, 0, 0, ACC, 32'h0BADF00D, 1, 1, il, dl, 1, 0, 32'h300, 0));
    il = 32'h0BADF00D;
    vt.push_back(mk(1, 32'h300, 0, 0, 0, 0, FREE, 0,           0, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, FREE, 0,                 1, 1, il, dl, 0, 0, 0, 0));

    // Abort: address moves 0x40 -> 0x44 while RAM busy
    vt.push_back(mk(1, 32'h40, 0, 0, 0, 0, FREE, 0,            1, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h40, 0, 0, 0, 0, BUSY, 0,            1, 1, il, dl, 1, 0, 32'h40, 0));
    vt.push_back(mk(1, 32'h44, 0, 0, 0, 0, BUSY, 0,            1, 1, il, dl, 1, 0, 32'h40, 0));
    vt.push_back(mk(1, 32'h44, 0, 0, 0, 0, FREE, 0,            1, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h44, 0, 0, 0, 0, ACC, 32'h12345678,  1, 1, il, dl, 1, 0, 32'h44, 0));
    il = 32'h12345678;
    vt.push_back(mk(1, 32'h44, 0, 0, 0, 0, FREE, 0,            0, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, FREE, 0,                 1, 1, il, dl, 0, 0, 0, 0));

    // Write survives requester dropping dWEN and changing address
    vt.push_back(mk(0, 0, 0, 1, 32'h400, 32'hCAFEF00D, FREE, 0, 1, 1, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 32'h400, 32'hCAFEF00D, BUSY, 0,
                    1, 1, il, dl, 0, 1, 32'h400, 32'hCAFEF00D));
    vt.push_back(mk(0, 0, 0, 0, 32'h404, 0, BUSY, 0,  1, 1, il, dl, 0, 1, 32'h400, 32'hCAFEF00D));
    vt.push_back(mk(0, 0, 0, 0, 32'h404, 0, ACC, 0,   1, 1, il, dl, 0, 1, 32'h400, 32'hCAFEF00D));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, FREE, 0,                 1, 0, il, dl, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, FREE, 0,                 1, 1, il, dl, 0, 0, 0, 0));

    nRST = 1'b0;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    repeat (2) @(negedge CLK);
    chk("reset_ramaddr", -1, ramaddr, 32'h0);
    chk("reset_ramstore", -1, ramstore, 32'h0);
    nRST = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge CLK);
      iREN = vt[i].iren;  iaddr = vt[i].iaddr;
      dREN = vt[i].dren;  dWEN = vt[i].dwen;
      daddr = vt[i].daddr; dstore = vt[i].dstore;
      ramstate = vt[i].rs; ramload = vt[i].rl;
      chk("iwait", i, 32'(iwait), 32'(vt[i].e_iwait));
      chk("dwait", i, 32'(dwait), 32'(vt[i].e_dwait));
      chk("iload", i, iload, vt[i].e_iload);
      chk("dload", i, dload, vt[i].e_dload);
      chk("ramREN", i, 32'(ramREN), 32'(vt[i].e_ren));
      chk("ramWEN", i, 32'(ramWEN), 32'(vt[i].e_wen));
      if (vt[i].e_ren || vt[i].e_wen) chk("ramaddr", i, ramaddr, vt[i].e_addr);
      if (vt[i].e_wen) chk("ramstore", i, ramstore, vt[i].e_store);
    end

    // Reset in the middle of a write
    @(negedge CLK);
    iREN = 0; dREN = 0; dWEN = 1; daddr = 32'h500; dstore = 32'h55AA55AA; ramstate = BUSY;
    @(negedge CLK);
    chk("mid_write_wen", 100, 32'(ramWEN), 32'h1);
    chk("mid_write_addr", 100, ramaddr, 32'h500);
    #2 nRST = 1'b0;
    #1;
    chk("rst_ramWEN", 101, 32'(ramWEN), 32'h0);
    chk("rst_ramREN", 101, 32'(ramREN), 32'h0);
    chk("rst_dwait", 101, 32'(dwait), 32'h1);
    chk("rst_iwait", 101, 32'(iwait), 32'h1);
    chk("rst_iload", 101, iload, 32'h0);
    chk("rst_dload", 101, dload, 32'h0);
    chk("rst_ramaddr", 101, ramaddr, 32'h0);
    chk("rst_ramstore", 101, ramstore, 32'h0);
    @(negedge CLK);
    dWEN = 0; daddr = 0; dstore = 0; ramstate = FREE;
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_wen", 102, 32'(ramWEN), 32'h0);
    chk("post_rst_dwait", 102, 32'(dwait), 32'h1);
    iREN = 1; iaddr = 32'h600; dREN = 1; daddr = 32'h700;
    @(negedge CLK);
    chk("post_rst_ren", 103, 32'(ramREN), 32'h1);
    chk("post_rst_grant", 103, ramaddr, 32'h700);
    iREN = 0; dREN = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
